wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Owns the register-file write port (wr_addr/wr_data/wr_en); it is the only writer.
//  Merges single-cycle ALU results with multi-cycle unit (MCU: div/load) results.
//  Buffers MCU results in a small FIFO and keeps a busy scoreboard of pending MCU rd.
//  Decode reads o_busy to stall on RAW/WAW hazards.
// PARAMETERS
//  REG_WIDTH    32  data width
//  FILE_DEPTH   32  number of architectural registers
//  FIFO_DEPTH   2   MCU result buffer entries (power of 2, >=2)
//  STARVE_LIMIT 4   consecutive cycles the FIFO head may lose to the ALU before stall request
//  ADDR_WIDTH   $clog2(FILE_DEPTH), derived, not overridable
// PORTS
//  i_clk          in   1           clock, all state on posedge
//  i_reset_n      in   1           async active-low reset
//  i_issue_valid  in   1           decode issued an MCU op this cycle
//  i_issue_rd     in   ADDR_WIDTH  destination of the issued MCU op
//  i_alu_valid    in   1           ALU result present (no backpressure)
//  i_alu_rd       in   ADDR_WIDTH  ALU destination
//  i_alu_data     in   REG_WIDTH   ALU result
//  i_mc_valid     in   1           MCU result valid
//  i_mc_rd        in   ADDR_WIDTH  MCU destination
//  i_mc_data      in   REG_WIDTH   MCU result
//  o_mc_ready     out  1           FIFO can accept (= !full, registered state)
//  o_wr_en        out  1           register-file write enable
//  o_wr_addr      out  ADDR_WIDTH  register-file write address
//  o_wr_data      out  REG_WIDTH   register-file write data
//  o_busy         out  FILE_DEPTH  bit r set = MCU write to r pending
//  o_stall_req    out  1           pipeline must hold i_alu_valid low next cycle
//  o_err          out  1           sticky protocol-violation flag
// BEHAVIOUR
//  Reset (async): FIFO empty, o_busy=0, starve count=0, o_stall_req=0, o_err=0, o_mc_ready=1.
//   o_wr_en=0 while i_reset_n low. Reset mid-operation discards FIFO contents and busy bits.
//  MCU accept: i_mc_valid && o_mc_ready pushes {rd,data} at the posedge. Accept when full is impossible.
//  Write-port mux (combinational from inputs/FIFO head, same cycle):
//   - o_stall_req=1 and FIFO non-empty: write FIFO head, pop.
//     A concurrent i_alu_valid is dropped and sets o_err.
//   - else if i_alu_valid: write ALU result; FIFO holds.
//   - else if FIFO non-empty: write FIFO head, pop.
//   - else o_wr_en=0; o_wr_addr/o_wr_data = 0.
//   - Selected rd==0: o_wr_en=0, but a FIFO pop still occurs.
//  Push and pop in the same cycle are both allowed; the count is unchanged.
//   A push into an empty FIFO is not written in that cycle.
//  Latency: MCU accepted in cycle N -> earliest o_wr_en in N+1 -> busy bit low from N+2.
//  Scoreboard, updated at the posedge:
//   - Set bit rd on i_issue_valid (rd!=0).
//   - Clear bit rd when its FIFO entry is popped.
//   - Same rd set and cleared in one cycle: set wins.
//   - Bit 0 is always 0.
//  o_err is set, and held until reset, on:
//   - a popped MCU entry whose busy bit is clear;
//   - i_alu_valid with a busy rd (WAW);
//   - a dropped ALU write.
//  Starvation: count +1 each cycle the FIFO is non-empty and the ALU wins; reset to 0 on any pop.
//   - count==STARVE_LIMIT: o_stall_req=1 (registered) next cycle.
//   - o_stall_req clears after the pop it enables.
//  FIFO pointers wrap modulo FIFO_DEPTH; full/empty come from a count register (0..FIFO_DEPTH).
// TESTING
//  1 ALU only: alu rd=5 data=0xA5 -> o_wr_en=1, addr=5, data=0xA5 same cycle; o_busy=0.
//  2 Issue rd=7, then mc rd=7 data=0x1234 with ALU idle ->
//    o_busy[7]=1 from next cycle; write 0x1234 one cycle after accept; bit clear one later.
//  3 Two MCU results back to back plus continuous ALU valid ->
//    o_mc_ready=0 when full; o_stall_req=1 after 4 lost cycles; head written on the stall cycle.
//  4 Issue rd=3 in the same cycle the FIFO pops rd=3 -> o_busy[3] stays 1.
//    rd=0 MCU result -> popped, no write.
//  5 Protocol violations: ALU valid during o_stall_req, ALU to busy rd, unexpected MCU rd ->
//    o_err=1 and sticky.
//  6 Assert reset with FIFO holding 2 entries -> immediately o_wr_en=0, o_busy=0, o_mc_ready=1;
//    no stale writes after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges ALU results with buffered MCU results.
// Keeps a busy scoreboard of pending MCU destinations and a starvation guard.
//
// Ports:
//   i_clk, i_reset_n            clock, async active-low reset
//   i_issue_valid/i_issue_rd    MCU op issued by decode (sets busy bit)
//   i_alu_valid/rd/data         single-cycle ALU result, no backpressure
//   i_mc_valid/rd/data          MCU result, accepted when o_mc_ready
//   o_mc_ready                  result FIFO not full
//   o_wr_en/addr/data           register-file write port
//   o_busy                      per-register pending MCU write
//   o_stall_req                 ALU must stay idle next cycle
//   o_err                       sticky protocol violation
module wb_arbiter #(
    parameter int REG_WIDTH    = 32,
    parameter int FILE_DEPTH   = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int ADDR_WIDTH  = $clog2(FILE_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_issue_valid,
    input  logic [ADDR_WIDTH-1:0] i_issue_rd,
    input  logic                  i_alu_valid,
    input  logic [ADDR_WIDTH-1:0] i_alu_rd,
    input  logic [REG_WIDTH-1:0]  i_alu_data,
    input  logic                  i_mc_valid,
    input  logic [ADDR_WIDTH-1:0] i_mc_rd,
    input  logic [REG_WIDTH-1:0]  i_mc_data,
    output logic                  o_mc_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [REG_WIDTH-1:0]  o_wr_data,
    output logic [FILE_DEPTH-1:0] o_busy,
    output logic                  o_stall_req,
    output logic                  o_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STV_LIMIT  = STV_W'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] RD_X0 = '0;

    // FIFO storage and control
    logic [ADDR_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_rd_d   [FIFO_DEPTH];
    logic [REG_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [REG_WIDTH-1:0]  fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Scoreboard, starvation guard, error flag
    logic [FILE_DEPTH-1:0] busy_q, busy_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic                  err_q, err_d;

    // Write-port selection
    logic                  fifo_ne;
    logic                  push;
    logic                  pop;
    logic                  alu_won;
    logic                  alu_drop;
    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [REG_WIDTH-1:0]  sel_data;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [REG_WIDTH-1:0]  head_data;
    logic                  wr_en;

    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];
    assign fifo_ne   = (count_q != '0);
    assign o_mc_ready = (count_q != CNT_FULL);
    assign push      = i_mc_valid && o_mc_ready;

    // Priority: forced drain under stall, then ALU, then FIFO head.
    always_comb begin
        pop       = 1'b0;
        alu_won   = 1'b0;
        alu_drop  = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (stall_q && fifo_ne) begin
            pop       = 1'b1;
            alu_drop  = i_alu_valid;
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_data  = head_data;
        end else if (i_alu_valid) begin
            alu_won   = fifo_ne;
            sel_valid = 1'b1;
            sel_rd    = i_alu_rd;
            sel_data  = i_alu_data;
        end else if (fifo_ne) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_data  = head_data;
        end
    end

    // x0 is never written; the port is also held quiet during reset.
    assign wr_en     = sel_valid && (sel_rd != RD_X0) && i_reset_n;
    assign o_wr_en   = wr_en;
    assign o_wr_addr = wr_en ? sel_rd : '0;
    assign o_wr_data = wr_en ? sel_data : '0;

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = i_mc_rd;
            fifo_data_d[wr_ptr_q] = i_mc_data;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Clear on pop first so a same-cycle issue to that rd keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (i_issue_valid) begin
            busy_d[i_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (pop) begin
            starve_d = '0;
            stall_d  = 1'b0;
        end else begin
            if (alu_won && (starve_q != STV_LIMIT)) begin
                starve_d = starve_q + 1'b1;
            end
            if (starve_d == STV_LIMIT) begin
                stall_d = 1'b1;
            end
        end
    end

    // Popping x0 is legal and untracked, so it never flags.
    always_comb begin
        err_d = err_q;
        if (pop && (head_rd != RD_X0) && !busy_q[head_rd]) begin
            err_d = 1'b1;
        end
        if (i_alu_valid && busy_q[i_alu_rd]) begin
            err_d = 1'b1;
        end
        if (alu_drop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_stall_req = stall_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy;
    logic        stall_req;
    logic        err;

    int checks = 0;
    int errors = 0;

    wb_arbiter dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_alu_valid   (alu_valid),
        .i_alu_rd      (alu_rd),
        .i_alu_data    (alu_data),
        .i_mc_valid    (mc_valid),
        .i_mc_rd       (mc_rd),
        .i_mc_data     (mc_data),
        .o_mc_ready    (mc_ready),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_busy        (busy),
        .o_stall_req   (stall_req),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = '0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        mc_valid    = 1'b0;
        mc_rd       = '0;
        mc_data     = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic mc(input logic [4:0] rd, input logic [31:0] d);
        mc_valid = 1'b1;
        mc_rd    = rd;
        mc_data  = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", mc_ready, 1);
        chk("rst_stall", stall_req, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ALU only
        alu(5, 32'hA5);
        #1;
        chk("t1_wr_en", wr_en, 1);
        chk("t1_addr", wr_addr, 5);
        chk("t1_data", wr_data, 32'hA5);
        chk("t1_busy", busy, 0);
        cyc();

        // 2: issue rd7, MCU result, busy lifetime
        idle();
        issue(7);
        #1;
        chk("t2_busy_pre", busy, 0);
        cyc();
        idle();
        mc(7, 32'h1234);
        #1;
        chk("t2_busy_set", busy, 32'h80);
        chk("t2_no_wr_push", wr_en, 0);
        cyc();
        idle();
        #1;
        chk("t2_wr_en", wr_en, 1);
        chk("t2_addr", wr_addr, 7);
        chk("t2_data", wr_data, 32'h1234);
        chk("t2_busy_hold", busy, 32'h80);
        cyc();
        #1;
        chk("t2_busy_clr", busy, 0);
        chk("t2_idle_wr", wr_en, 0);
        chk("t2_err", err, 0);

        // 3: fill FIFO under ALU pressure, starvation stall
        issue(8);
        cyc();
        idle();
        issue(9);
        cyc();
        idle();
        mc(8, 32'h88);
        alu(10, 32'h10);
        #1;
        chk("t3_ready0", mc_ready, 1);
        chk("t3_alu10", wr_addr, 10);
        cyc();
        idle();
        mc(9, 32'h99);
        alu(11, 32'h11);
        #1;
        chk("t3_alu_wins", wr_addr, 11);
        chk("t3_ready1", mc_ready, 1);
        cyc();
        idle();
        alu(12, 32'h12);
        #1;
        chk("t3_full", mc_ready, 0);
        chk("t3_alu12", wr_data, 32'h12);
        cyc();
        alu(13, 32'h13);
        #1;
        chk("t3_nostall13", stall_req, 0);
        cyc();
        alu(14, 32'h14);
        #1;
        chk("t3_nostall14", stall_req, 0);
        cyc();
        idle();
        #1;
        chk("t3_stall", stall_req, 1);
        chk("t3_head_en", wr_en, 1);
        chk("t3_head_addr", wr_addr, 8);
        chk("t3_head_data", wr_data, 32'h88);
        cyc();
        #1;
        chk("t3_stall_clr", stall_req, 0);
        chk("t3_ready", mc_ready, 1);
        chk("t3_busy", busy, 32'h200);
        chk("t3_second", wr_addr, 9);
        chk("t3_second_d", wr_data, 32'h99);
        chk("t3_err", err, 0);
        cyc();
        #1;
        chk("t3_busy0", busy, 0);

        // 4: set wins over clear; rd0 entries pop silently
        issue(3);
        cyc();
        idle();
        mc(3, 32'h33);
        cyc();
        idle();
        issue(3);
        #1;
        chk("t4_wr3", wr_addr, 3);
        cyc();
        idle();
        #1;
        chk("t4_busy3", busy, 32'h8);
        mc(0, 32'hDEAD);
        cyc();
        idle();
        mc(0, 32'hBEEF);
        #1;
        chk("t4_rd0_nowr", wr_en, 0);
        cyc();
        idle();
        #1;
        chk("t4_rd0_popped", mc_ready, 1);
        chk("t4_rd0_nowr2", wr_en, 0);
        cyc();
        #1;
        chk("t4_err", err, 0);

        // 5a: MCU result for a register not pending
        do_reset();
        mc(6, 32'h1);
        cyc();
        idle();
        #1;
        chk("t5a_wr", wr_addr, 6);
        chk("t5a_err_pre", err, 0);
        cyc();
        #1;
        chk("t5a_err", err, 1);
        cyc();
        #1;
        chk("t5a_sticky", err, 1);

        // 5b: ALU write to a busy register
        do_reset();
        #1;
        chk("t5b_err_rst", err, 0);
        issue(4);
        cyc();
        idle();
        alu(4, 32'h5);
        #1;
        chk("t5b_err_pre", err, 0);
        cyc();
        idle();
        #1;
        chk("t5b_err", err, 1);

        // 5c: ALU valid while stall is requested
        do_reset();
        issue(20);
        cyc();
        idle();
        mc(20, 32'h2020);
        alu(21, 32'h21);
        cyc();
        idle();
        for (int i = 22; i < 26; i++) begin
            alu(5'(i), 32'(i));
            cyc();
        end
        alu(26, 32'h26);
        #1;
        chk("t5c_stall", stall_req, 1);
        chk("t5c_head", wr_addr, 20);
        chk("t5c_head_d", wr_data, 32'h2020);
        chk("t5c_err_pre", err, 0);
        cyc();
        idle();
        #1;
        chk("t5c_err", err, 1);
        chk("t5c_stall_clr", stall_req, 0);

        // 6: reset with two entries buffered
        do_reset();
        issue(15);
        cyc();
        issue(16);
        cyc();
        idle();
        mc(15, 32'h15);
        alu(1, 32'h1);
        cyc();
        idle();
        mc(16, 32'h16);
        alu(2, 32'h2);
        cyc();
        idle();
        #1;
        chk("t6_full", mc_ready, 0);
        chk("t6_busy", busy, 32'h18000);
        rst_n = 1'b0;
        alu(3, 32'h3);
        #1;
        chk("t6_rst_wr", wr_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", mc_ready, 1);
        cyc();
        idle();
        rst_n = 1'b1;
        #1;
        chk("t6_post_wr", wr_en, 0);
        cyc();
        #1;
        chk("t6_post_wr2", wr_en, 0);
        chk("t6_post_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
